// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_OFF_L   = 7'h7F;
   localparam logic [3:0] ANODE_OFF_L = 4'hF;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Bit i set when nibbles i..top are all zero; digit 0 is never marked.
   function automatic logic [NUM_DIGITS-1:0] lz_mask(
      input logic [4*NUM_DIGITS-1:0] v
   );
      logic zero;
      zero    = 1'b1;
      lz_mask = '0;
      for (int i = NUM_DIGITS-1; i > 0; i--) begin
         zero       = zero && (v[4*i +: 4] == 4'h0);
         lz_mask[i] = zero;
      end
   endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-high segment decoder.
// Pattern source is the shared package table.
module hex7seg_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with
// frame-aligned value updates and registered pin outputs.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 4
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value_in,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [3:0]  digit_en,
   input  logic [3:0]  dp_in,
   input  logic        lz_en,
   output logic [6:0]  seg_L,
   output logic        dp_L,
   output logic [3:0]  anode_L
);

   localparam int CW = $clog2(REFRESH_DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   disp_q, disp_d;
   logic [15:0]   shadow_q, shadow_d;
   logic          pending_q, pending_d;
   logic [3:0]    anode_q, anode_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          tc;
   logic          boundary;
   logic          accept;
   logic [3:0]    nib;
   logic [6:0]    seg_hi;
   logic [3:0]    sup;
   logic          visible;

   assign tc       = (cnt_q == CW'(REFRESH_DIV - 1));
   assign boundary = tc && (idx_q == 2'd3);
   assign accept   = load_valid && !pending_q;

   assign nib = disp_q[{idx_q, 2'b00} +: 4];
   assign sup = lz_en ? lz_mask(disp_q) : 4'b0000;

   assign visible = (cnt_q >= CW'(GUARD))
                 && digit_en[idx_q]
                 && !sup[idx_q];

   hex7seg_decode u_dec (
      .nib_i (nib),
      .seg_o (seg_hi)
   );

   always_comb begin
      cnt_d     = tc ? '0 : cnt_q + 1'b1;
      idx_d     = tc ? idx_q + 2'd1 : idx_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      disp_d    = disp_q;
      if (accept) begin
         shadow_d  = value_in;
         pending_d = 1'b1;
      end
      // accept and commit are exclusive: accept needs pending clear
      if (boundary && pending_q) begin
         disp_d    = shadow_q;
         pending_d = 1'b0;
      end
   end

   always_comb begin
      anode_d = ANODE_OFF_L;
      seg_d   = SEG_OFF_L;
      dp_d    = 1'b1;
      if (visible) begin
         anode_d = ~(4'b0001 << idx_q);
         seg_d   = ~seg_hi;
         dp_d    = ~dp_in[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         idx_q     <= 2'd0;
         disp_q    <= 16'h0000;
         shadow_q  <= 16'h0000;
         pending_q <= 1'b0;
         anode_q   <= ANODE_OFF_L;
         seg_q     <= SEG_OFF_L;
         dp_q      <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         disp_q    <= disp_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         anode_q   <= anode_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign load_ready = ~pending_q;
   assign anode_L    = anode_q;
   assign seg_L      = seg_q;
   assign dp_L       = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a queue of expected
// {anode_L, seg_L, dp_L} words, one per clock.
module tb_seg7_scan_ctrl;

   localparam int RD    = 8;
   localparam int GD    = 2;
   localparam int FRAME = 4 * RD;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value_in;
   logic        load_valid;
   logic        load_ready;
   logic [3:0]  digit_en;
   logic [3:0]  dp_in;
   logic        lz_en;
   logic [6:0]  seg_L;
   logic        dp_L;
   logic [3:0]  anode_L;

   int vectors    = 0;
   int miscompares = 0;
   int edges      = 0;

   logic [11:0] expq[$];
   logic [6:0]  tbl[16];

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
      .clk        (clk),
      .reset      (reset),
      .value_in   (value_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .digit_en   (digit_en),
      .dp_in      (dp_in),
      .lz_en      (lz_en),
      .seg_L      (seg_L),
      .dp_L       (dp_L),
      .anode_L    (anode_L)
   );

   task automatic chk(input string tag, input logic [11:0] got,
                      input logic [11:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s at edge %0d: observed %h expected %h",
                tag, edges, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      edges++;
      #1;
   endtask

   // Output word expected after edge n (reflects counter state n-1).
   function automatic logic [11:0] exp_out(input int n,
                                           input logic [15:0] v);
      int c, i;
      logic [15:0] hi;
      logic [3:0] nb;
      logic on;
      c  = (n - 1) % RD;
      i  = ((n - 1) / RD) % 4;
      hi = v >> (4 * i);
      nb = hi[3:0];
      on = (c >= GD) && digit_en[i] && !(lz_en && i > 0 && hi == 16'h0);
      if (on)
         return {~(4'b0001 << i), ~tbl[nb], ~dp_in[i]};
      return 12'hFFF;
   endfunction

   task automatic run(input logic [15:0] v, input int n);
      for (int k = 1; k <= n; k++)
         expq.push_back(exp_out(edges + k, v));
      for (int k = 0; k < n; k++) begin
         tick();
         chk("scan", {anode_L, seg_L, dp_L}, expq.pop_front());
      end
   endtask

   task automatic chk_ready(input string tag, input logic exp);
      chk(tag, {11'd0, load_ready}, {11'd0, exp});
   endtask

   // Starting at a frame start: load newv, old value finishes the
   // current frame, newv shows in the following one.
   task automatic load_and_show(input logic [15:0] newv,
                                input logic [15:0] oldv);
      chk_ready("ready_pre", 1'b1);
      load_valid = 1'b1;
      value_in   = newv;
      run(oldv, 1);
      load_valid = 1'b0;
      value_in   = 16'hDEAD;
      chk_ready("ready_pend", 1'b0);
      run(oldv, FRAME - 1);
      chk_ready("ready_commit", 1'b1);
      run(newv, FRAME);
   endtask

   initial begin
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      reset      = 1'b1;
      value_in   = 16'h0;
      load_valid = 1'b0;
      digit_en   = 4'hF;
      dp_in      = 4'h0;
      lz_en      = 1'b0;
      tick();
      tick();
      chk("reset_out", {anode_L, seg_L, dp_L}, 12'hFFF);
      chk_ready("reset_ready", 1'b1);
      reset = 1'b0;
      edges = 0;

      // 1: basic load, frame 0 shows 0000, frame 1 shows 1234
      load_and_show(16'h1234, 16'h0000);

      // 2: handshake with load_valid held during pending window
      chk_ready("hs_ready", 1'b1);
      load_valid = 1'b1;
      value_in   = 16'hAAAA;
      run(16'h1234, 1);
      value_in = 16'h5555;
      while (edges % FRAME != 0) begin
         chk_ready("hs_blocked", 1'b0);
         run(16'h1234, 1);
      end
      chk_ready("hs_reopen", 1'b1);
      run(16'hAAAA, 1);
      load_valid = 1'b0;
      chk_ready("hs_pend2", 1'b0);
      run(16'hAAAA, FRAME - 1);
      run(16'h5555, FRAME);

      // 3: accept coincides with frame boundary
      run(16'h5555, FRAME - 1);
      chk_ready("co_ready", 1'b1);
      load_valid = 1'b1;
      value_in   = 16'hBEEF;
      run(16'h5555, 1);
      load_valid = 1'b0;
      chk_ready("co_pend", 1'b0);
      run(16'h5555, FRAME);
      chk_ready("co_commit", 1'b1);
      run(16'hBEEF, FRAME);

      // 4: leading-zero suppression
      lz_en = 1'b1;
      load_and_show(16'h0070, 16'hBEEF);
      load_and_show(16'h0000, 16'h0070);

      // 5: digit enables and decimal point
      lz_en    = 1'b0;
      digit_en = 4'b0101;
      dp_in    = 4'b0001;
      load_and_show(16'hF0F0, 16'h0000);

      // 6: reset mid-slot discards pending value
      load_valid = 1'b1;
      value_in   = 16'h9999;
      run(16'hF0F0, 1);
      load_valid = 1'b0;
      run(16'hF0F0, 10);
      chk_ready("rst_pend", 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_out", {anode_L, seg_L, dp_L}, 12'hFFF);
      chk_ready("rst_ready", 1'b1);
      edges    = 0;
      digit_en = 4'hF;
      dp_in    = 4'h0;
      run(16'h0000, 2 * FRAME);
      chk("q_empty", 12'(expq.size()), 12'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
